// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reservation_station_pkg;

    localparam int RS_SIZE  = 8;                // entries, power of two, >= 2
    localparam int ROB_W    = 4;                // ROB tag width, tag 0 = no dependency
    localparam int OP_W     = 6;                // opcode enum width
    localparam int RS_POS_W = $clog2(RS_SIZE);

    typedef logic [31:0]         data_t;
    typedef logic [ROB_W-1:0]    rob_pos_t;
    typedef logic [OP_W-1:0]     openum_t;
    typedef logic [RS_POS_W-1:0] rs_pos_t;

    localparam rob_pos_t ZERO_ROB  = '0;
    localparam data_t    ZERO_WORD = '0;

    localparam openum_t OPENUM_NOP   = 6'd0;
    localparam openum_t OPENUM_LUI   = 6'd1;
    localparam openum_t OPENUM_AUIPC = 6'd2;
    localparam openum_t OPENUM_JAL   = 6'd3;
    localparam openum_t OPENUM_JALR  = 6'd4;
    localparam openum_t OPENUM_BEQ   = 6'd5;
    localparam openum_t OPENUM_BNE   = 6'd6;
    localparam openum_t OPENUM_BLT   = 6'd7;
    localparam openum_t OPENUM_BGE   = 6'd8;
    localparam openum_t OPENUM_BLTU  = 6'd9;
    localparam openum_t OPENUM_BGEU  = 6'd10;
    localparam openum_t OPENUM_ADD   = 6'd11;
    localparam openum_t OPENUM_SUB   = 6'd12;
    localparam openum_t OPENUM_SLL   = 6'd13;
    localparam openum_t OPENUM_SLT   = 6'd14;
    localparam openum_t OPENUM_SLTU  = 6'd15;
    localparam openum_t OPENUM_XOR   = 6'd16;
    localparam openum_t OPENUM_SRL   = 6'd17;
    localparam openum_t OPENUM_SRA   = 6'd18;
    localparam openum_t OPENUM_OR    = 6'd19;
    localparam openum_t OPENUM_AND   = 6'd20;
    localparam openum_t OPENUM_ADDI  = 6'd21;
    localparam openum_t OPENUM_SLTI  = 6'd22;
    localparam openum_t OPENUM_SLTIU = 6'd23;
    localparam openum_t OPENUM_XORI  = 6'd24;
    localparam openum_t OPENUM_ORI   = 6'd25;
    localparam openum_t OPENUM_ANDI  = 6'd26;
    localparam openum_t OPENUM_SLLI  = 6'd27;
    localparam openum_t OPENUM_SRLI  = 6'd28;
    localparam openum_t OPENUM_SRAI  = 6'd29;

    // One operand slot: producer tag plus value (value meaningful when q == 0).
    typedef struct packed {
        rob_pos_t q;
        data_t    v;
    } operand_t;

    typedef struct packed {
        logic     busy;
        openum_t  op;
        data_t    vj;
        rob_pos_t qj;
        data_t    vk;
        rob_pos_t qk;
        data_t    imm;
        data_t    pc;
        rob_pos_t tag;
    } rs_entry_t;

    // Resolve an operand against both result buses. The ALU bus wins a tie;
    // a waiting tag is never 0, so an idle bus (tag 0) can never match.
    function automatic operand_t resolve_operand(
        input rob_pos_t q,
        input data_t    v,
        input rob_pos_t alu_tag,
        input data_t    alu_value,
        input rob_pos_t lsb_tag,
        input data_t    lsb_value
    );
        operand_t res;
        res.q = q;
        res.v = v;
        if (q != ZERO_ROB) begin
            if (q == alu_tag) begin
                res.q = ZERO_ROB;
                res.v = alu_value;
            end else if (q == lsb_tag) begin
                res.q = ZERO_ROB;
                res.v = lsb_value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index find-first over a request vector (free slots / ready entries).
// Latency: purely combinational.
// Backpressure: none; found=0 when no bit is set (idx then 0).
// Ports: req[N] in, idx out (lowest set bit index), found out.
module reservation_station_select #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last write.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops until operands arrive, issues one ready op per cycle.
// Latency: dispatch-ready at edge E issues at E+1; wakeup at edge E issues no earlier than E+1.
// Backpressure: out_full stalls dispatch (requests while full are dropped); rdy=0 freezes everything.
// Ports: clk/rst(async active-low)/rdy/in_clear; in_* dispatch; alu_*/lsb_* result buses;
//        out_full; out_op/out_value1/out_value2/out_imm/out_pc/out_rob_tag registered to the ALU.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     in_clear,
    input  logic     in_valid,
    input  openum_t  in_op,
    input  data_t    in_vj,
    input  data_t    in_vk,
    input  rob_pos_t in_qj,
    input  rob_pos_t in_qk,
    input  data_t    in_imm,
    input  data_t    in_pc,
    input  rob_pos_t in_rob_tag,
    input  rob_pos_t alu_tag,
    input  data_t    alu_value,
    input  rob_pos_t lsb_tag,
    input  data_t    lsb_value,
    output logic     out_full,
    output openum_t  out_op,
    output data_t    out_value1,
    output data_t    out_value2,
    output data_t    out_imm,
    output data_t    out_pc,
    output rob_pos_t out_rob_tag
);

    rs_entry_t entries [RS_SIZE];

    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    rs_pos_t            free_idx;
    rs_pos_t            iss_idx;
    logic               free_found;
    logic               iss_found;

    operand_t wake_j [RS_SIZE];
    operand_t wake_k [RS_SIZE];
    operand_t disp_j;
    operand_t disp_k;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !entries[i].busy;
            ready_vec[i] = entries[i].busy && (entries[i].qj == ZERO_ROB)
                                           && (entries[i].qk == ZERO_ROB);
        end
    end

    reservation_station_select #(.N(RS_SIZE), .IDX_W(RS_POS_W)) u_free_sel (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    reservation_station_select #(.N(RS_SIZE), .IDX_W(RS_POS_W)) u_issue_sel (
        .req   (ready_vec),
        .idx   (iss_idx),
        .found (iss_found)
    );

    assign out_full = !free_found;

    // Wakeup candidates for every entry, plus same-cycle bypass for the incoming op.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j[i] = resolve_operand(entries[i].qj, entries[i].vj,
                                        alu_tag, alu_value, lsb_tag, lsb_value);
            wake_k[i] = resolve_operand(entries[i].qk, entries[i].vk,
                                        alu_tag, alu_value, lsb_tag, lsb_value);
        end
        disp_j = resolve_operand(in_qj, in_vj, alu_tag, alu_value, lsb_tag, lsb_value);
        disp_k = resolve_operand(in_qk, in_vk, alu_tag, alu_value, lsb_tag, lsb_value);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries[i] <= '0;
            end
            out_op      <= OPENUM_NOP;
            out_value1  <= ZERO_WORD;
            out_value2  <= ZERO_WORD;
            out_imm     <= ZERO_WORD;
            out_pc      <= ZERO_WORD;
            out_rob_tag <= ZERO_ROB;
        end else if (rdy) begin
            if (in_clear) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    entries[i].busy <= 1'b0;
                end
                out_op      <= OPENUM_NOP;
                out_value1  <= ZERO_WORD;
                out_value2  <= ZERO_WORD;
                out_imm     <= ZERO_WORD;
                out_pc      <= ZERO_WORD;
                out_rob_tag <= ZERO_ROB;
            end else begin
                // Wakeup only rewrites operand fields of occupied entries, so it
                // never collides with the dispatch write into a free slot.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (entries[i].busy) begin
                        entries[i].qj <= wake_j[i].q;
                        entries[i].vj <= wake_j[i].v;
                        entries[i].qk <= wake_k[i].q;
                        entries[i].vk <= wake_k[i].v;
                    end
                end

                // Issue is chosen from pre-edge state, so a just-written or
                // just-woken entry waits at least one more edge.
                if (iss_found) begin
                    out_op                <= entries[iss_idx].op;
                    out_value1            <= entries[iss_idx].vj;
                    out_value2            <= entries[iss_idx].vk;
                    out_imm               <= entries[iss_idx].imm;
                    out_pc                <= entries[iss_idx].pc;
                    out_rob_tag           <= entries[iss_idx].tag;
                    entries[iss_idx].busy <= 1'b0;
                end else begin
                    out_op      <= OPENUM_NOP;
                    out_value1  <= ZERO_WORD;
                    out_value2  <= ZERO_WORD;
                    out_imm     <= ZERO_WORD;
                    out_pc      <= ZERO_WORD;
                    out_rob_tag <= ZERO_ROB;
                end

                if (in_valid && free_found) begin
                    entries[free_idx] <= '{busy: 1'b1,
                                           op:   in_op,
                                           vj:   disp_j.v,
                                           qj:   disp_j.q,
                                           vk:   disp_k.v,
                                           qk:   disp_k.q,
                                           imm:  in_imm,
                                           pc:   in_pc,
                                           tag:  in_rob_tag};
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with hand-computed expectations.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns after the next one.
// Backpressure: exercises full/drop, clear and rdy freeze.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     rdy;
    logic     in_clear;
    logic     in_valid;
    openum_t  in_op;
    data_t    in_vj, in_vk, in_imm, in_pc;
    rob_pos_t in_qj, in_qk, in_rob_tag;
    rob_pos_t alu_tag, lsb_tag;
    data_t    alu_value, lsb_value;
    logic     out_full;
    openum_t  out_op;
    data_t    out_value1, out_value2, out_imm, out_pc;
    rob_pos_t out_rob_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .in_clear    (in_clear),
        .in_valid    (in_valid),
        .in_op       (in_op),
        .in_vj       (in_vj),
        .in_vk       (in_vk),
        .in_qj       (in_qj),
        .in_qk       (in_qk),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .in_rob_tag  (in_rob_tag),
        .alu_tag     (alu_tag),
        .alu_value   (alu_value),
        .lsb_tag     (lsb_tag),
        .lsb_value   (lsb_value),
        .out_full    (out_full),
        .out_op      (out_op),
        .out_value1  (out_value1),
        .out_value2  (out_value2),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_rob_tag (out_rob_tag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid   = 1'b0;
        in_clear   = 1'b0;
        in_op      = OPENUM_NOP;
        in_vj      = '0;
        in_vk      = '0;
        in_qj      = '0;
        in_qk      = '0;
        in_imm     = '0;
        in_pc      = '0;
        in_rob_tag = '0;
        alu_tag    = '0;
        alu_value  = '0;
        lsb_tag    = '0;
        lsb_value  = '0;
    endtask

    task automatic dispatch(input openum_t op, input data_t vj, input rob_pos_t qj,
                            input data_t vk, input rob_pos_t qk, input data_t imm,
                            input data_t pc, input rob_pos_t tag);
        in_valid   = 1'b1;
        in_op      = op;
        in_vj      = vj;
        in_qj      = qj;
        in_vk      = vk;
        in_qk      = qk;
        in_imm     = imm;
        in_pc      = pc;
        in_rob_tag = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        drive_idle();
        #3;
        // Reset state, before any clock edge (asynchronous).
        chk("rst_op",   32'(out_op), 32'(OPENUM_NOP));
        chk("rst_full", 32'(out_full), 32'd0);
        chk("rst_v1",   out_value1, 32'd0);
        chk("rst_tag",  32'(out_rob_tag), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: ready ADD issues the edge after dispatch, then NOP.
        dispatch(OPENUM_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 32'd0, 32'h100, 4'd3);
        tick();
        drive_idle();
        chk("t1_no_same_edge", 32'(out_op), 32'(OPENUM_NOP));
        tick();
        chk("t1_op",  32'(out_op), 32'(OPENUM_ADD));
        chk("t1_v1",  out_value1, 32'd5);
        chk("t1_v2",  out_value2, 32'd7);
        chk("t1_pc",  out_pc, 32'h100);
        chk("t1_tag", 32'(out_rob_tag), 32'd3);
        tick();
        chk("t1_nop",     32'(out_op), 32'(OPENUM_NOP));
        chk("t1_nop_tag", 32'(out_rob_tag), 32'd0);
        chk("t1_nop_v1",  out_value1, 32'd0);

        // 2: ADDI waits on tag 4, woken by the ALU bus.
        dispatch(OPENUM_ADDI, 32'hdead, 4'd4, 32'd0, 4'd0, 32'd1, 32'h104, 4'd2);
        tick();
        drive_idle();
        tick();
        chk("t2_waiting", 32'(out_op), 32'(OPENUM_NOP));
        alu_tag   = 4'd4;
        alu_value = 32'd9;
        tick();
        drive_idle();
        chk("t2_wake_edge", 32'(out_op), 32'(OPENUM_NOP));
        tick();
        chk("t2_op",  32'(out_op), 32'(OPENUM_ADDI));
        chk("t2_v1",  out_value1, 32'd9);
        chk("t2_imm", out_imm, 32'd1);
        chk("t2_tag", 32'(out_rob_tag), 32'd2);
        tick();

        // 3: same-cycle bypass from the LSB bus at dispatch.
        dispatch(OPENUM_SUB, 32'hbeef, 4'd5, 32'd3, 4'd0, 32'd0, 32'h108, 4'd7);
        lsb_tag   = 4'd5;
        lsb_value = 32'h10;
        tick();
        drive_idle();
        chk("t3_no_same_edge", 32'(out_op), 32'(OPENUM_NOP));
        tick();
        chk("t3_op",  32'(out_op), 32'(OPENUM_SUB));
        chk("t3_v1",  out_value1, 32'h10);
        chk("t3_v2",  out_value2, 32'd3);
        chk("t3_tag", 32'(out_rob_tag), 32'd7);
        tick();

        // 4: fill all entries waiting on tag 6, drop a 9th, then drain in order.
        for (int i = 0; i < RS_SIZE; i++) begin
            dispatch(OPENUM_ADD, 32'd0, 4'd6, 32'(i), 4'd0, 32'd0, 32'(i), rob_pos_t'(8 + i));
            tick();
        end
        drive_idle();
        chk("t4_full", 32'(out_full), 32'd1);
        chk("t4_nop",  32'(out_op), 32'(OPENUM_NOP));
        dispatch(OPENUM_OR, 32'd1, 4'd0, 32'd1, 4'd0, 32'd0, 32'd0, 4'd1);
        tick();
        drive_idle();
        chk("t4_full_after_drop", 32'(out_full), 32'd1);
        tick();
        chk("t4_dropped_no_issue", 32'(out_op), 32'(OPENUM_NOP));
        alu_tag   = 4'd6;
        alu_value = 32'h66;
        tick();
        drive_idle();
        chk("t4_wake_edge", 32'(out_op), 32'(OPENUM_NOP));
        for (int i = 0; i < RS_SIZE; i++) begin
            tick();
            chk("t4_drain_tag", 32'(out_rob_tag), 32'(8 + i));
            chk("t4_drain_v1",  out_value1, 32'h66);
            chk("t4_drain_v2",  out_value2, 32'(i));
            if (i == 0) chk("t4_full_drops", 32'(out_full), 32'd0);
        end
        tick();
        chk("t4_empty_nop", 32'(out_op), 32'(OPENUM_NOP));

        // 5: three ready entries flushed by in_clear, with a discarded dispatch.
        for (int i = 0; i < 3; i++) begin
            dispatch(OPENUM_XOR, 32'(i), 4'd0, 32'd0, 4'd3, 32'd0, 32'd0, rob_pos_t'(1 + i));
            tick();
        end
        drive_idle();
        alu_tag   = 4'd3;
        alu_value = 32'h33;
        tick();
        drive_idle();
        dispatch(OPENUM_ADD, 32'd1, 4'd0, 32'd1, 4'd0, 32'd0, 32'd0, 4'd12);
        in_clear = 1'b1;
        tick();
        drive_idle();
        chk("t5_clear_op",   32'(out_op), 32'(OPENUM_NOP));
        chk("t5_clear_full", 32'(out_full), 32'd0);
        chk("t5_clear_tag",  32'(out_rob_tag), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_stale", 32'(out_op), 32'(OPENUM_NOP));
        end

        // 6: rdy=0 freezes outputs and state while a broadcast is present.
        dispatch(OPENUM_ADD, 32'd0, 4'd9, 32'd0, 4'd0, 32'd0, 32'd0, 4'd10);
        tick();
        dispatch(OPENUM_OR, 32'd1, 4'd0, 32'd2, 4'd0, 32'd0, 32'h200, 4'd4);
        tick();
        dispatch(OPENUM_AND, 32'h30, 4'd0, 32'h40, 4'd0, 32'd0, 32'h204, 4'd11);
        tick();
        drive_idle();
        chk("t6_pre_op",  32'(out_op), 32'(OPENUM_OR));
        chk("t6_pre_tag", 32'(out_rob_tag), 32'd4);
        rdy       = 1'b0;
        alu_tag   = 4'd9;
        alu_value = 32'h99;
        dispatch(OPENUM_ADD, 32'd1, 4'd0, 32'd1, 4'd0, 32'd0, 32'd0, 4'd13);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_frozen_op",  32'(out_op), 32'(OPENUM_OR));
            chk("t6_frozen_tag", 32'(out_rob_tag), 32'd4);
            chk("t6_frozen_v1",  out_value1, 32'd1);
        end
        rdy      = 1'b1;
        in_valid = 1'b0;
        tick();
        drive_idle();
        chk("t6_resume_op",  32'(out_op), 32'(OPENUM_AND));
        chk("t6_resume_tag", 32'(out_rob_tag), 32'd11);
        chk("t6_resume_v1",  out_value1, 32'h30);
        chk("t6_resume_v2",  out_value2, 32'h40);
        tick();
        chk("t6_woken_op",  32'(out_op), 32'(OPENUM_ADD));
        chk("t6_woken_tag", 32'(out_rob_tag), 32'd10);
        chk("t6_woken_v1",  out_value1, 32'h99);
        tick();
        chk("t6_final_nop", 32'(out_op), 32'(OPENUM_NOP));
        chk("t6_final_tag", 32'(out_rob_tag), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
